fft_sched_ctrl: RTL and testbench
=================================

# fft_sched_ctrl

Sequencer for the 64-point in-place radix-2 FFT datapath and its working memory.
- Accepts one complex sample per handshake beat and issues load write addresses.
- Steps the butterfly unit through all stages with address pair and twiddle index, and issues write-back addresses.
- Drives unload reads two samples per cycle, matching the two-lane output (`outReal0`/`outImag0`, `outReal1`/`outImag1`).
- Carries no sample data; control and addressing only.

## Interface
- `LOG2N`, 6, log2 of FFT size N. Widths below use A=`LOG2N` and T=`LOG2N`-1.
- `BF_LAT`, 3, butterfly pipeline latency in cycles, from issue to write-back. Range 1..7.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request to begin a frame.
- `in_valid` in 1: input sample present.
- `in_ready` out 1: controller accepts an input sample.
- `ld_we` out 1: memory write enable, load phase.
- `ld_addr` out A: load write address.
- `bf_valid` out 1: butterfly issue strobe.
- `bf_addr_a`, `bf_addr_b` out A: butterfly operand addresses.
- `tw_idx` out T: twiddle ROM index.
- `stage` out 3: current stage number.
- `wb_we` out 1: write-back enable.
- `wb_addr_a`, `wb_addr_b` out A: write-back addresses.
- `rd_en` out 1: unload read enable.
- `rd_addr0`, `rd_addr1` out A: unload read addresses, lane 0 and lane 1.
- `out_valid` out 1: unload data valid at the memory read port.
- `out_idx` out T: index of the output pair.
- `busy` out 1: high in any state except IDLE.
- `done` out 1: one-cycle end-of-frame pulse.

## Operation
- States: IDLE, LOAD, COMPUTE, DRAIN, UNLOAD, FLUSH.
- IDLE → LOAD on `start`. `start` is ignored in any other state.
- LOAD:
  - `in_ready`=1.
  - Beat = `in_valid` & `in_ready`.
  - Each beat: `ld_we`=1 for that cycle and sample counter c increments.
  - After beat N-1, go to COMPUTE with stage=0, j=0.
- COMPUTE:
  - One butterfly per cycle: `bf_valid`=1, j = 0..N/2-1.
  - After j=N/2-1, go to DRAIN.
- DRAIN:
  - `bf_valid`=0 for `BF_LAT` cycles.
  - This is a stage data hazard barrier.
  - Then stage increments and the state returns to COMPUTE with j=0.
  - After the last stage, go to UNLOAD instead.
- UNLOAD:
  - `rd_en`=1 for N/2 cycles, pair i = 0..N/2-1.
  - Then go to FLUSH.
- FLUSH:
  - One cycle.
  - `out_valid` for the last pair and `done`=1.
  - Then go to IDLE.
- Write-back:
  - `wb_we`, `wb_addr_a` and `wb_addr_b` equal `bf_valid`, `bf_addr_a` and `bf_addr_b` delayed by exactly `BF_LAT` cycles.
  - Implemented as a shift register.
- `out_valid`/`out_idx` equal `rd_en`/i delayed by 1 cycle (memory read latency).
- Address arithmetic is unsigned and modulo N.
- Butterfly schedule with `FFT_BITREV_LOAD_EN` defined (DIT):
  - Span h = 2^stage.
  - k = j mod h.
  - a = (j>>stage)·2h + k, b = a+h.
  - `tw_idx` = k<<(T-stage).
- Butterfly schedule without `FFT_BITREV_LOAD_EN` (DIF):
  - Span h = 2^(T-stage).
  - k = j mod h.
  - a = (j>>(T-stage))·2h + k, b = a+h.
  - `tw_idx` = k<<stage.

## Timing
- Reset: every output is 0, all counters are 0, state is IDLE, and the write-back shift register is cleared.
- Reset mid-frame: in-flight write-backs are discarded.
- Rising edge after deassertion: the block is ready for `start`.
- `in_ready` rises the cycle after `start` is sampled.
- `in_ready` falls the cycle after beat N-1.
- Beats may be non-consecutive. `in_valid` gaps only stretch LOAD.
- Beat N-1 at cycle t:
  - first `bf_valid` at t+1;
  - COMPUTE plus DRAIN last LOG2N·(N/2+`BF_LAT`) cycles (210 with the defaults);
  - first `rd_en` at t+211;
  - last `rd_en` at t+242;
  - `done` at t+243.
- Every `wb_we` completes inside its stage's DRAIN window, so it never overlaps the next stage's `bf_valid` reads of the same address.
- `busy` falls in the cycle after `done`. `start` in that same cycle is accepted.

## Configuration
- `FFT_BITREV_LOAD_EN` defined:
  - DIT schedule;
  - `ld_addr` = bitrev(c);
  - `rd_addr0` = 2i, `rd_addr1` = 2i+1 (natural output).
- `FFT_BITREV_LOAD_EN` undefined:
  - DIF schedule;
  - `ld_addr` = c (natural input);
  - `rd_addr0` = bitrev(2i), `rd_addr1` = bitrev(2i+1).
- bitrev reverses A bits.

## Test plan
- Reset: assert `rst` asynchronously between edges.
  - Required: all outputs 0 immediately.
  - Required: `start` after release yields `in_ready`=1 the next cycle.
- LOAD with macro, `in_valid` toggling every other cycle.
  - Required: 64 beats.
  - Required: `ld_addr` sequence 0, 32, 16, 48, 8, …, 63.
  - Required: `in_ready` drops after the 64th beat and ignores further `in_valid`.
- COMPUTE with macro.
  - Required: stage 0 issues (0,1,tw0), (2,3,tw0).
  - Required: stage 5 issues j=1 as (1,33,tw1).
  - Required: `wb_we` pattern matches `bf_valid` shifted by 3.
  - Required: exactly 3 idle cycles between stages.
- UNLOAD with macro.
  - Required: pairs (0,1) … (62,63).
  - Required: `out_valid`/`out_idx` one cycle later.
  - Required: `done` is 243 cycles after the last load beat.
- `start` pulsed during COMPUTE.
  - Required: no effect.
- `rst` during COMPUTE stage 3.
  - Required: IDLE, `wb_we`=0 throughout, and a fresh frame completes normally.
- Without macro.
  - Required: `ld_addr` = 0, 1, 2, ….
  - Required: stage 0 issues j=0 as (0,32,tw0) and j=1 as (1,33,tw1).
  - Required: unload pair 0 is (0,32) and pair 1 is (16,48).

Source files
------------

// File: rtl/fft_sched_ctrl.sv
// Control and address sequencer for a 64-point in-place radix-2 FFT: load, compute/drain, unload.
// Define FFT_BITREV_LOAD_EN for a DIT schedule with bit-reversed load; otherwise DIF with
// bit-reversed unload.
module fft_sched_ctrl #(
  parameter int unsigned LOG2N  = 6,
  parameter int unsigned BF_LAT = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  output logic               ld_we_o,
  output logic [LOG2N-1:0]   ld_addr_o,
  output logic               bf_valid_o,
  output logic [LOG2N-1:0]   bf_addr_a_o,
  output logic [LOG2N-1:0]   bf_addr_b_o,
  output logic [LOG2N-2:0]   tw_idx_o,
  output logic [2:0]         stage_o,
  output logic               wb_we_o,
  output logic [LOG2N-1:0]   wb_addr_a_o,
  output logic [LOG2N-1:0]   wb_addr_b_o,
  output logic               rd_en_o,
  output logic [LOG2N-1:0]   rd_addr0_o,
  output logic [LOG2N-1:0]   rd_addr1_o,
  output logic               out_valid_o,
  output logic [LOG2N-2:0]   out_idx_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam int unsigned A    = LOG2N;
  localparam int unsigned T    = LOG2N - 1;
  localparam int unsigned N    = 1 << LOG2N;
  localparam int unsigned HALF = N / 2;
  // Shared counter must also reach BF_LAT-1 (up to 6) for the drain window.
  localparam int unsigned CW   = (A > 3) ? A : 3;

  typedef enum logic [2:0] {StIdle, StLoad, StCompute, StDrain, StUnload, StFlush} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      stage_q, stage_d;

  logic [BF_LAT-1:0]         wb_we_q;
  logic [BF_LAT-1:0][A-1:0]  wb_a_q, wb_b_q;
  logic                      out_valid_q;
  logic [T-1:0]              out_idx_q;

  logic [A-1:0]  j_w, h_w, k_w, a_w;
  logic [2:0]    span_sh;
  logic [T-1:0]  tw_w;

  function automatic logic [A-1:0] bitrev(input logic [A-1:0] x);
    logic [A-1:0] r;
    for (int unsigned n = 0; n < A; n++) begin
      r[n] = x[A-1-n];
    end
    return r;
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      stage_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StLoad;
          cnt_d   = '0;
          stage_d = '0;
        end
      end
      StLoad: begin
        if (in_valid_i) begin
          if (cnt_q == CW'(N - 1)) begin
            state_d = StCompute;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      StCompute: begin
        if (cnt_q == CW'(HALF - 1)) begin
          state_d = StDrain;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StDrain: begin
        if (cnt_q == CW'(BF_LAT - 1)) begin
          cnt_d = '0;
          if (stage_q == 3'(LOG2N - 1)) begin
            state_d = StUnload;
            stage_d = '0;
          end else begin
            state_d = StCompute;
            stage_d = stage_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StUnload: begin
        if (cnt_q == CW'(HALF - 1)) begin
          state_d = StFlush;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StFlush: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Butterfly address generation: span, in-group offset and twiddle from stage and j.
  always_comb begin
    j_w = A'(cnt_q[T-1:0]);
`ifdef FFT_BITREV_LOAD_EN
    span_sh = stage_q;
`else
    span_sh = 3'(T) - stage_q;
`endif
    h_w = A'(1) << span_sh;
    k_w = j_w & (h_w - A'(1));
    a_w = ((j_w >> span_sh) << (span_sh + 3'd1)) + k_w;
`ifdef FFT_BITREV_LOAD_EN
    tw_w = T'(k_w << (3'(T) - stage_q));
`else
    tw_w = T'(k_w << stage_q);
`endif
  end

  always_comb begin
    in_ready_o  = (state_q == StLoad);
    ld_we_o     = in_ready_o & in_valid_i;
    ld_addr_o   = '0;
    bf_valid_o  = (state_q == StCompute);
    bf_addr_a_o = '0;
    bf_addr_b_o = '0;
    tw_idx_o    = '0;
    stage_o     = stage_q;
    rd_en_o     = (state_q == StUnload);
    rd_addr0_o  = '0;
    rd_addr1_o  = '0;
    busy_o      = (state_q != StIdle);
    done_o      = (state_q == StFlush);
    if (in_ready_o) begin
`ifdef FFT_BITREV_LOAD_EN
      ld_addr_o = bitrev(cnt_q[A-1:0]);
`else
      ld_addr_o = cnt_q[A-1:0];
`endif
    end
    if (bf_valid_o) begin
      bf_addr_a_o = a_w;
      bf_addr_b_o = a_w + h_w;
      tw_idx_o    = tw_w;
    end
    if (rd_en_o) begin
`ifdef FFT_BITREV_LOAD_EN
      rd_addr0_o = {cnt_q[T-1:0], 1'b0};
      rd_addr1_o = {cnt_q[T-1:0], 1'b1};
`else
      rd_addr0_o = bitrev({cnt_q[T-1:0], 1'b0});
      rd_addr1_o = bitrev({cnt_q[T-1:0], 1'b1});
`endif
    end
  end

  // Write-back delay line; cleared by reset so in-flight results are dropped.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wb_we_q <= '0;
      wb_a_q  <= '0;
      wb_b_q  <= '0;
    end else begin
      wb_we_q[0] <= bf_valid_o;
      wb_a_q[0]  <= bf_addr_a_o;
      wb_b_q[0]  <= bf_addr_b_o;
      for (int unsigned n = 1; n < BF_LAT; n++) begin
        wb_we_q[n] <= wb_we_q[n-1];
        wb_a_q[n]  <= wb_a_q[n-1];
        wb_b_q[n]  <= wb_b_q[n-1];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
    end else begin
      out_valid_q <= rd_en_o;
      out_idx_q   <= rd_en_o ? cnt_q[T-1:0] : '0;
    end
  end

  assign wb_we_o     = wb_we_q[BF_LAT-1];
  assign wb_addr_a_o = wb_a_q[BF_LAT-1];
  assign wb_addr_b_o = wb_b_q[BF_LAT-1];
  assign out_valid_o = out_valid_q;
  assign out_idx_o   = out_idx_q;

endmodule

// File: tb/tb_fft_sched_ctrl.sv
// Scoreboard bench for fft_sched_ctrl: a timeline model pushes expected strobes, a monitor pops them.
module tb_fft_sched_ctrl;

  localparam int LOG2N = 6;
  localparam int N     = 64;
  localparam int H     = 32;
  localparam int BFL   = 3;
  localparam int BIG   = 1 << 30;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready, ld_we, bf_valid, wb_we, rd_en, out_valid, busy, done;
  logic [LOG2N-1:0] ld_addr, bf_addr_a, bf_addr_b, wb_addr_a, wb_addr_b, rd_addr0, rd_addr1;
  logic [LOG2N-2:0] tw_idx, out_idx;
  logic [2:0] stage;

  fft_sched_ctrl #(.LOG2N(LOG2N), .BF_LAT(BFL)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .in_valid_i(in_valid),
    .in_ready_o(in_ready), .ld_we_o(ld_we), .ld_addr_o(ld_addr),
    .bf_valid_o(bf_valid), .bf_addr_a_o(bf_addr_a), .bf_addr_b_o(bf_addr_b),
    .tw_idx_o(tw_idx), .stage_o(stage),
    .wb_we_o(wb_we), .wb_addr_a_o(wb_addr_a), .wb_addr_b_o(wb_addr_b),
    .rd_en_o(rd_en), .rd_addr0_o(rd_addr0), .rd_addr1_o(rd_addr1),
    .out_valid_o(out_valid), .out_idx_o(out_idx), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int cyc; int a; int b; int c; int d;} ev_t;
  ev_t q[6][$];

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;
  int busy_from = BIG, busy_until = -1;
  int ir_from = BIG, ir_until = -1;

  function automatic int brev(input int x);
    int r = 0;
    for (int b = 0; b < LOG2N; b++) if (((x >> b) & 1) == 1) r += 2 ** (LOG2N - 1 - b);
    return r;
  endfunction

  function automatic void push(input int id, input int cy, input int a, input int b,
                               input int c, input int d);
    ev_t e;
    e.cyc = cy; e.a = a; e.b = b; e.c = c; e.d = d;
    q[id].push_back(e);
  endfunction

  // Whole-frame timeline derived from the cycle of the last load beat.
  function automatic void push_frame(input int t);
    int h, k, a, tw, cy, base;
    for (int st = 0; st < LOG2N; st++) begin
      for (int j = 0; j < H; j++) begin
`ifdef FFT_BITREV_LOAD_EN
        h = 2 ** st;
        k = j % h;
        tw = k * (2 ** (LOG2N - 1 - st));
`else
        h = 2 ** (LOG2N - 1 - st);
        k = j % h;
        tw = k * (2 ** st);
`endif
        a = (j / h) * 2 * h + k;
        cy = t + 1 + st * (H + BFL) + j;
        push(1, cy, a, a + h, tw, st);
        push(2, cy + BFL, a, a + h, 0, 0);
      end
    end
    base = t + 1 + LOG2N * (H + BFL);
    for (int i = 0; i < H; i++) begin
`ifdef FFT_BITREV_LOAD_EN
      push(3, base + i, 2 * i, 2 * i + 1, 0, 0);
`else
      push(3, base + i, brev(2 * i), brev(2 * i + 1), 0, 0);
`endif
      push(4, base + i + 1, i, 0, 0, 0);
    end
    push(5, base + H, 0, 0, 0, 0);
    busy_until = base + H;
  endfunction

  task automatic chk(input int id, input string nm, input logic vis, input int a, input int b,
                     input int c, input int d);
    ev_t e;
    if (vis === 1'b1) begin
      checks++;
      if (q[id].size() == 0 || q[id][0].cyc != cyc) begin
        errors++;
        $display("FAIL %s cyc=%0d unexpected strobe got a=%0d b=%0d c=%0d d=%0d", nm, cyc, a, b, c, d);
      end else begin
        e = q[id].pop_front();
        if (e.a != a || e.b != b || e.c != c || e.d != d) begin
          errors++;
          $display("FAIL %s cyc=%0d got a=%0d b=%0d c=%0d d=%0d exp a=%0d b=%0d c=%0d d=%0d",
                   nm, cyc, a, b, c, d, e.a, e.b, e.c, e.d);
        end
      end
    end else if (q[id].size() != 0 && q[id][0].cyc == cyc) begin
      checks++;
      errors++;
      e = q[id].pop_front();
      $display("FAIL %s cyc=%0d missing strobe got 0 exp a=%0d b=%0d", nm, cyc, e.a, e.b);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      chk(0, "ld", ld_we, int'(ld_addr), 0, 0, 0);
      chk(1, "bf", bf_valid, int'(bf_addr_a), int'(bf_addr_b), int'(tw_idx), int'(stage));
      chk(2, "wb", wb_we, int'(wb_addr_a), int'(wb_addr_b), 0, 0);
      chk(3, "rd", rd_en, int'(rd_addr0), int'(rd_addr1), 0, 0);
      chk(4, "ov", out_valid, int'(out_idx), 0, 0, 0);
      chk(5, "done", done, 0, 0, 0, 0);
      checks += 2;
      if (busy !== (cyc >= busy_from && cyc <= busy_until)) begin
        errors++;
        $display("FAIL busy cyc=%0d got %0b exp %0b", cyc, busy, cyc >= busy_from && cyc <= busy_until);
      end
      if (in_ready !== (cyc >= ir_from && cyc <= ir_until)) begin
        errors++;
        $display("FAIL in_ready cyc=%0d got %0b exp %0b", cyc, in_ready, cyc >= ir_from && cyc <= ir_until);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_zero(input string nm);
    logic [127:0] all;
    all = 128'({in_ready, ld_we, ld_addr, bf_valid, bf_addr_a, bf_addr_b, tw_idx, stage, wb_we,
                wb_addr_a, wb_addr_b, rd_en, rd_addr0, rd_addr1, out_valid, out_idx, busy, done});
    checks++;
    if (all !== '0) begin
      errors++;
      $display("FAIL %s outputs got %0h exp 0", nm, all);
    end
  endtask

  // mode 0: in_valid every other cycle; mode 1: random gaps. Called at an idle cycle.
  task automatic frame(input int mode, input bit rst_mid);
    int s, c, t;
    bit v;
    s = cyc;
    t = BIG;
    start = 1'b1;
    busy_from = s + 1; busy_until = BIG;
    ir_from = s + 1; ir_until = BIG;
    tick();
    start = 1'b0;
    c = 0;
    while (c < N) begin
      v = (mode == 0) ? ((cyc - s) % 2 == 1) : ($urandom_range(0, 3) != 0);
      in_valid = v;
      if (v) begin
`ifdef FFT_BITREV_LOAD_EN
        push(0, cyc, brev(c), 0, 0, 0);
`else
        push(0, cyc, c, 0, 0, 0);
`endif
        c++;
        if (c == N) begin
          t = cyc;
          ir_until = t;
        end
      end
      tick();
    end
    in_valid = 1'b1;
    push_frame(t);
    tick();
    tick();
    in_valid = 1'b0;
    if (rst_mid) begin
      while (cyc < t + 1 + 3 * (H + BFL) + 6) tick();
      #1 rst = 1'b1;
      #1 check_zero("rst_mid");
      for (int id = 0; id < 6; id++) q[id].delete();
      busy_from = BIG; busy_until = -1;
      ir_from = BIG; ir_until = -1;
      tick();
      tick();
      #1 rst = 1'b0;
      tick();
    end else begin
      while (cyc < t + 40) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      while (cyc < t + 244) tick();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    tick();
    tick();
    #1 rst = 1'b1;
    #1 check_zero("reset");
    tick();
    #1 rst = 1'b0;
    mon_en = 1'b1;
    tick();
    frame(0, 1'b0);
    frame(1, 1'b0);
    frame(1, 1'b1);
    tick();
    frame(1, 1'b0);
    repeat (5) tick();
    for (int id = 0; id < 6; id++) begin
      checks++;
      if (q[id].size() != 0) begin
        errors++;
        $display("FAIL leftover queue %0d got %0d entries exp 0", id, q[id].size());
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
